// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the iceMCU UART receive path.
//   uart_rx_state_t : receiver FSM states
//   OS_RATE         : oversample ticks per bit
//   SAMPLE_LO/MID/HI: oversample positions captured for the majority vote
//   DATA_BITS       : payload bits per frame (8N1)
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_rx_state_t;

    localparam int OS_RATE    = 16;
    localparam int SAMPLE_LO  = 7;
    localparam int SAMPLE_MID = 8;
    localparam int SAMPLE_HI  = 9;
    localparam int DATA_BITS  = 8;

    localparam int OS_CNT_W  = $clog2(OS_RATE);
    localparam int BIT_CNT_W = $clog2(DATA_BITS);

endpackage

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// Synchronous first-word-fall-through FIFO holding received bytes.
// A pop frees its slot in the same cycle, so a push while full succeeds when
// it coincides with a pop. A push that finds the FIFO full with no pop is
// ignored; the caller reports that as an overrun.
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   push         : write push_data this cycle
//   push_data    : byte to store
//   pop          : consume the head entry (ignored while empty)
//   head_data    : current head entry, 0 while empty
//   full, empty  : occupancy flags
// -----------------------------------------------------------------------------
module uart_rx_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head_data,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count;
    logic              pop_ok;
    logic              push_ok;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    // Gating with empty keeps the visible byte at 0 after reset even though
    // the storage array itself is not reset.
    assign head_data = empty ? '0 : mem[rd_ptr];

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_rx_core.sv
// -----------------------------------------------------------------------------
// uart_rx_core
// 8N1 UART receiver with 16x oversampling and 3-sample majority voting.
// Received bytes are offered on a valid/ready interface; framing errors,
// overruns and false starts are detected.
// Build option: define UART_RX_FIFO_EN to buffer bytes in a FIFO_DEPTH-entry
// FWFT FIFO; otherwise a single holding register is used.
// Parameters:
//   OS_DIV     : clk cycles per oversample tick (>= 2)
//   FIFO_DEPTH : FIFO entries, power of two >= 2 (FIFO build only)
// Ports:
//   clk, reset_n : clock, asynchronous active-low reset
//   RX           : serial input, idle high, asynchronous to clk
//   rx_data      : received byte, valid while rx_valid
//   rx_valid     : a byte is available
//   rx_ready     : consumer accepts the byte on rx_valid && rx_ready
//   frame_err    : one-cycle pulse, stop bit sampled 0
//   overrun      : one-cycle pulse, good byte dropped because storage full
//   busy         : receiver FSM is not idle
// -----------------------------------------------------------------------------
module uart_rx_core
    import uart_pkg::*;
#(
    parameter int OS_DIV     = 26,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       RX,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun,
    output logic       busy
);

    localparam int                DIV_W    = $clog2(OS_DIV);
    localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(OS_DIV - 1);
    localparam logic [OS_CNT_W-1:0]  OS_LO   = OS_CNT_W'(SAMPLE_LO);
    localparam logic [OS_CNT_W-1:0]  OS_MID  = OS_CNT_W'(SAMPLE_MID);
    localparam logic [OS_CNT_W-1:0]  OS_HI   = OS_CNT_W'(SAMPLE_HI);
    localparam logic [OS_CNT_W-1:0]  OS_LAST = OS_CNT_W'(OS_RATE - 1);
    localparam logic [BIT_CNT_W-1:0] BIT_LAST = BIT_CNT_W'(DATA_BITS - 1);

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    uart_rx_state_t         state;
    uart_rx_state_t         state_nxt;
    logic                   rx_meta_p0;
    logic                   rx_s;
    logic [DIV_W-1:0]       div_cnt;
    logic [OS_CNT_W-1:0]    os_cnt;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic [DATA_BITS-1:0]   shreg;
    logic                   samp_lo;
    logic                   samp_mid;
    logic                   tick;
    logic                   vote;
    logic                   bit_end;
    logic                   maj;
    logic                   push;
    logic                   fe_set;
    logic                   pop;
    logic                   overrun_set;

    // ---- stage 0/1: two-flop synchronizer, idles high ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_p0 <= 1'b1;
            rx_s       <= 1'b1;
        end else begin
            rx_meta_p0 <= RX;
            rx_s       <= rx_meta_p0;
        end
    end

    // ---- oversample timing ----
    // Counters are held at zero while idle, so the first clock in START is
    // phase zero of the start bit.
    assign tick    = (state != IDLE) && (div_cnt == DIV_LAST);
    assign vote    = tick && (os_cnt == OS_HI);
    assign bit_end = tick && (os_cnt == OS_LAST);
    assign maj     = maj3(samp_lo, samp_mid, rx_s);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
            os_cnt  <= '0;
        end else if (state == IDLE) begin
            div_cnt <= '0;
            os_cnt  <= '0;
        end else if (tick) begin
            div_cnt <= '0;
            os_cnt  <= os_cnt + 1'b1;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // The third vote sample is rx_s itself on the vote tick.
    always_ff @(posedge clk) begin
        if (tick && (os_cnt == OS_LO))  samp_lo  <= rx_s;
        if (tick && (os_cnt == OS_MID)) samp_mid <= rx_s;
    end

    // ---- bit counter and deserializer ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bit_cnt <= '0;
            shreg   <= '0;
        end else begin
            if (state == START && bit_end)     bit_cnt <= '0;
            else if (state == DATA && bit_end) bit_cnt <= bit_cnt + 1'b1;
            // LSB arrives first, so shifting right leaves it at bit 0.
            if (state == DATA && vote) shreg <= {maj, shreg[DATA_BITS-1:1]};
        end
    end

    // ---- FSM: state register ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // ---- FSM: next state ----
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (!rx_s) state_nxt = START;
            START: begin
                if (vote && maj)  state_nxt = IDLE;
                else if (bit_end) state_nxt = DATA;
            end
            DATA:  if (bit_end && bit_cnt == BIT_LAST) state_nxt = STOP;
            // Leaving at the stop vote lets the next start edge be caught in
            // the second half of the stop bit.
            STOP:  if (vote) state_nxt = maj ? IDLE : BREAK;
            BREAK: if (rx_s) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ---- FSM: outputs ----
    always_comb begin
        push   = 1'b0;
        fe_set = 1'b0;
        if (state == STOP && vote) begin
            push   = maj;
            fe_set = !maj;
        end
    end

    // ---- byte storage ----
`ifdef UART_RX_FIFO_EN
    logic fifo_full;
    logic fifo_empty;

    assign pop         = rx_valid && rx_ready;
    assign rx_valid    = !fifo_empty;
    assign overrun_set = push && fifo_full && !pop;

    uart_rx_fifo #(
        .DATA_W     (DATA_BITS),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (push),
        .push_data (shreg),
        .pop       (pop),
        .head_data (rx_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );
`else
    assign pop         = rx_valid && rx_ready;
    assign overrun_set = push && rx_valid && !pop;

    // A pop in the same cycle frees the register for the incoming byte.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_data  <= '0;
            rx_valid <= 1'b0;
        end else if (push && (!rx_valid || pop)) begin
            rx_data  <= shreg;
            rx_valid <= 1'b1;
        end else if (pop) begin
            rx_valid <= 1'b0;
        end
    end
`endif

    // ---- registered status ----
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_err <= 1'b0;
            overrun   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            frame_err <= fe_set;
            overrun   <= overrun_set;
            busy      <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_uart_rx_core.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_core
// Scoreboard bench for uart_rx_core with OS_DIV=4 (64 clk per bit).
// Stimulus pushes expected bytes into exp_q; a monitor pops and compares on
// every accepted byte and counts frame_err / overrun pulses.
// -----------------------------------------------------------------------------
module tb_uart_rx_core;

    localparam int OS_DIV     = 4;
    localparam int FIFO_DEPTH = 4;
    localparam int BIT_CLK    = 16 * OS_DIV;
    localparam int SPIKE_C    = 9 * OS_DIV;   // lands on the os_cnt=8 sample
    localparam int FULL_FRM   = 10 * BIT_CLK;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       RX = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b0;
    logic       frame_err;
    logic       overrun;
    logic       busy;

    uart_rx_core #(
        .OS_DIV     (OS_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .RX        (RX),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int         n_tests = 0;
    int         n_fail  = 0;
    int         fe_cnt  = 0;
    int         ov_cnt  = 0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: sampled on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (reset_n) begin
            if (frame_err) fe_cnt++;
            if (overrun)   ov_cnt++;
            if (rx_valid && rx_ready) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_byte: got %0h expected none", rx_data);
                end else begin
                    check("rx_byte", {24'h0, rx_data}, {24'h0, exp_q.pop_front()});
                end
            end
        end
    end

    task automatic idle(input int n);
        RX = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one 8N1 frame, one RX value per clk. spike_bit selects a data bit
    // that gets a single inverted clk at the os_cnt=8 sample (-1: none).
    // Returns early after max_cyc clocks, leaving RX at its last value.
    task automatic send_frame(input logic [7:0] b, input logic stop,
                              input int spike_bit, input int max_cyc);
        int   n = 0;
        logic v;
        for (int k = 0; k < 10; k++) begin
            if (k == 0)      v = 1'b0;
            else if (k == 9) v = stop;
            else             v = b[k-1];
            for (int c = 0; c < BIT_CLK; c++) begin
                if (n == max_cyc) return;
                @(posedge clk);
                #1;
                RX = (k == spike_bit + 1 && c == SPIKE_C) ? ~v : v;
                n++;
            end
        end
    endtask

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("reset_rx_data",   {24'h0, rx_data}, 32'h0);
        check("reset_rx_valid",  {31'h0, rx_valid}, 32'h0);
        check("reset_frame_err", {31'h0, frame_err}, 32'h0);
        check("reset_overrun",   {31'h0, overrun}, 32'h0);
        check("reset_busy",      {31'h0, busy}, 32'h0);
        reset_n = 1'b1;
        idle(10);

        // Basic frame
        rx_ready = 1'b1;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, -1, FULL_FRM);
        idle(20);
        check("basic_busy_idle", {31'h0, busy}, 32'h0);
        check("basic_no_fe", fe_cnt, 0);
        check("basic_no_ov", ov_cnt, 0);
        check("basic_drained", exp_q.size(), 0);

        // Glitch rejection
        @(posedge clk);
        #1;
        RX = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        check("glitch_busy_start", {31'h0, busy}, 32'h1);
        RX = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        check("glitch_back_idle", {31'h0, busy}, 32'h0);
        check("glitch_no_fe", fe_cnt, 0);

        // Framing error and break
        idle(20);
        send_frame(8'h3C, 1'b0, -1, FULL_FRM);
        repeat (2000) @(posedge clk);
        #1;
        check("break_busy", {31'h0, busy}, 32'h1);
        check("break_one_fe", fe_cnt, 1);
        RX = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("break_released", {31'h0, busy}, 32'h0);
        idle(50);
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, -1, FULL_FRM);
        idle(20);
        check("after_break_fe", fe_cnt, 1);
        check("after_break_drained", exp_q.size(), 0);

        // Overrun
        rx_ready = 1'b0;
        begin
            logic [7:0] frm [5];
            int         ov_exp [5];
            frm[0] = 8'h11; frm[1] = 8'h22; frm[2] = 8'h33; frm[3] = 8'h44; frm[4] = 8'h55;
`ifdef UART_RX_FIFO_EN
            ov_exp[0] = 0; ov_exp[1] = 0; ov_exp[2] = 0; ov_exp[3] = 0; ov_exp[4] = 1;
            for (int i = 0; i < 4; i++) exp_q.push_back(frm[i]);
`else
            ov_exp[0] = 0; ov_exp[1] = 1; ov_exp[2] = 2; ov_exp[3] = 3; ov_exp[4] = 4;
            exp_q.push_back(frm[0]);
`endif
            for (int i = 0; i < 5; i++) begin
                send_frame(frm[i], 1'b1, -1, FULL_FRM);
                idle(10);
                check("overrun_count", ov_cnt, ov_exp[i]);
            end
            check("overrun_head_11", {24'h0, rx_data}, 32'h11);
            rx_ready = 1'b1;
            repeat (10) @(posedge clk);
            #1;
            check("overrun_drained", exp_q.size(), 0);
            check("overrun_valid_low", {31'h0, rx_valid}, 32'h0);
            ov_cnt = 0;
        end

        // Noise spikes and back-to-back frames
        idle(20);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_frame(8'h00, 1'b1, 3, FULL_FRM);
        send_frame(8'hFF, 1'b1, 5, FULL_FRM);
        idle(20);
        check("noise_drained", exp_q.size(), 0);
        check("noise_no_fe", fe_cnt, 1);
        check("noise_no_ov", ov_cnt, 0);

        // Reset mid-frame, with a byte left pending so the reset has work to do
        rx_ready = 1'b0;
        exp_q.push_back(8'h77);
        send_frame(8'h77, 1'b1, -1, FULL_FRM);
        idle(10);
        check("pre_reset_valid", {31'h0, rx_valid}, 32'h1);
        send_frame(8'h5A, 1'b1, -1, 5 * BIT_CLK + BIT_CLK / 2);
        check("pre_reset_busy", {31'h0, busy}, 32'h1);
        #3;
        reset_n = 1'b0;
        #1;
        exp_q.delete();
        check("midrst_rx_data",   {24'h0, rx_data}, 32'h0);
        check("midrst_rx_valid",  {31'h0, rx_valid}, 32'h0);
        check("midrst_frame_err", {31'h0, frame_err}, 32'h0);
        check("midrst_overrun",   {31'h0, overrun}, 32'h0);
        check("midrst_busy",      {31'h0, busy}, 32'h0);
        RX = 1'b1;
        repeat (5) @(posedge clk);
        #4;
        reset_n = 1'b1;
        rx_ready = 1'b1;
        idle(20);
        exp_q.push_back(8'hC3);
        send_frame(8'hC3, 1'b1, -1, FULL_FRM);
        idle(30);
        check("post_reset_drained", exp_q.size(), 0);
        check("post_reset_idle", {31'h0, busy}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
